// File: rtl/hack_bus_pkg.sv
// Shared widths and state/tag encodings for the Hack data-RAM bus.
package hack_bus_pkg;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } owner_t;
endpackage

// File: rtl/ram_arb_burst_gen.sv
// DMA burst sequencer: remaining-beat counter and wrapping next-beat address.
module ram_arb_burst_gen
    import hack_bus_pkg::*;
#(
    parameter int BURST_W = 4
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               load_i,
    input  logic               advance_i,
    input  logic [ADDR_W-1:0]  start_addr_i,
    input  logic [BURST_W-1:0] len_i,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               last_o
);
    logic [BURST_W-1:0] len_left_q, len_left_d;
    logic [ADDR_W-1:0]  next_addr_q, next_addr_d;

    // Beat 0 goes out directly from the start address, so the register holds start+1.
    always_comb begin
        len_left_d  = len_left_q;
        next_addr_d = next_addr_q;
        if (load_i) begin
            len_left_d  = len_i;
            next_addr_d = start_addr_i + 1'b1;
        end else if (advance_i) begin
            len_left_d  = len_left_q - 1'b1;
            next_addr_d = next_addr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            len_left_q  <= '0;
            next_addr_q <= '0;
        end else begin
            len_left_q  <= len_left_d;
            next_addr_q <= next_addr_d;
        end
    end

    assign addr_o = next_addr_q;
    assign last_o = (len_left_q == BURST_W'(1));
endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the single-port data RAM between CPU word accesses and
// non-preemptible DMA read bursts, with a bounded wait for the DMA.
module ram_arbiter
    import hack_bus_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int BURST_W  = 4
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_gnt,
    output logic               cpu_rvalid,
    output logic [DATA_W-1:0]  cpu_rdata,
    input  logic               dma_req,
    input  logic [ADDR_W-1:0]  dma_addr,
    input  logic [BURST_W-1:0] dma_len,
    output logic               dma_gnt,
    output logic               dma_rvalid,
    output logic [DATA_W-1:0]  dma_rdata,
    output logic               dma_done,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    arb_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    owner_t            owner_q, owner_d;
    logic              last_q, last_d;

    logic              in_arb, dma_win, cpu_win, beat, burst_last;
    logic [ADDR_W-1:0] burst_addr;

    // Grants are gated by reset so nothing is accepted while it is held.
    assign in_arb  = reset && (state_q == ARB);
    assign dma_win = in_arb && dma_req && (!cpu_req || (wait_cnt_q == WAIT_W'(MAX_WAIT)));
    assign cpu_win = in_arb && cpu_req && !dma_win;
    assign beat    = reset && (state_q == BURST);

    ram_arb_burst_gen #(.BURST_W(BURST_W)) u_burst_gen (
        .CLK          (CLK),
        .reset        (reset),
        .load_i       (dma_win),
        .advance_i    (beat),
        .start_addr_i (dma_addr),
        .len_i        (dma_len),
        .addr_o       (burst_addr),
        .last_o       (burst_last)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        owner_d    = NONE;
        last_d     = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        if (dma_win) begin
            mem_addr   = dma_addr;
            owner_d    = DMA;
            last_d     = (dma_len == '0);
            wait_cnt_d = '0;
            if (dma_len != '0) state_d = BURST;
        end else if (beat) begin
            mem_addr = burst_addr;
            owner_d  = DMA;
            last_d   = burst_last;
            if (burst_last) state_d = ARB;
        end else if (cpu_win) begin
            mem_addr   = cpu_addr;
            mem_we     = cpu_we;
            mem_wdata  = cpu_wdata;
            owner_d    = cpu_we ? NONE : CPU;
            wait_cnt_d = dma_req ? wait_cnt_q + 1'b1 : '0;
        end else if (in_arb) begin
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= ARB;
            wait_cnt_q <= '0;
            owner_q    <= NONE;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
        end
    end

    assign cpu_gnt    = cpu_win;
    assign dma_gnt    = dma_win;
    assign cpu_rvalid = (owner_q == CPU);
    assign dma_rvalid = (owner_q == DMA);
    assign dma_done   = dma_rvalid && last_q;
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port Hack data RAM (15-bit word address, 16-bit data) between the CPU data port and a read-only screen-scanout DMA engine. The CPU gets per-word priority; the DMA issues non-preemptible read bursts of 1–16 words, with a bounded-wait rule so it is never starved. The block sits between the CPU/DMA masters and the `Memory` instance and drives the RAM command port.

## Interface
Parameters:
- `MAX_WAIT`, 4: number of consecutive cycles a pending DMA request may lose to the CPU before it is forced to win.
- `BURST_W`, 4: width of `dma_len`; maximum burst is 2^BURST_W words.

Ports:
- `CLK` in 1: the single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU word request.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 15: CPU word address.
- `cpu_wdata` in 16: CPU write data.
- `cpu_gnt` out 1: request accepted this cycle (combinational).
- `cpu_rvalid` out 1: CPU read data valid (registered pulse).
- `cpu_rdata` out 16: CPU read data.
- `dma_req` in 1: burst request, sampled only in ARB.
- `dma_addr` in 15: burst start address.
- `dma_len` in BURST_W: burst length minus 1.
- `dma_gnt` out 1: burst start accepted (combinational, one cycle).
- `dma_rvalid` out 1: DMA read data valid, one pulse per beat.
- `dma_rdata` out 16: DMA read data.
- `dma_done` out 1: pulses with the last beat's `dma_rvalid`.
- `mem_addr` out 15: RAM address.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out 16: RAM write data.
- `mem_rdata` in 16: RAM read data, valid the cycle after the address.

## Operation
- **FSM states:** ARB and BURST.
- **ARB with only `cpu_req`:** `cpu_gnt`=1. The memory port is driven from the CPU signals.
- **ARB with only `dma_req`:** `dma_gnt`=1.
  - Beat 0 (address `dma_addr`) is issued.
  - `len_left` is loaded with `dma_len` and `next_addr` with `dma_addr`+1.
  - If `dma_len`≠0, go to BURST.
- **ARB with both requests:**
  - If `wait_cnt` < MAX_WAIT: the CPU wins and `wait_cnt`++.
  - If `wait_cnt` = MAX_WAIT: the DMA wins.
  - `wait_cnt` clears whenever the DMA wins or `dma_req` is low.
- **BURST:**
  - Issues one read per cycle at `next_addr`, then `next_addr`++ and `len_left`--.
  - Address increment wraps modulo 2^15 (0x7FFF → 0x0000).
  - Returns to ARB after the beat with `len_left`=1.
  - `cpu_gnt`=0 throughout; `dma_req` is ignored.
- **DMA writes:** none. `mem_we` = `cpu_gnt & cpu_we` only.
- **Idle memory port:** `mem_addr`=0, `mem_we`=0, `mem_wdata`=0.
- **Read return:**
  - A registered owner tag (NONE/CPU/DMA) and a last-beat flag select which `rvalid` pulses in the next cycle.
  - `rdata` outputs are `mem_rdata` passed through, valid only while the matching `rvalid` is high.
  - CPU writes produce no `rvalid`.
- **Reset (asserted low, at any time, including mid-burst):**
  - Returns to ARB with `wait_cnt`=0 and owner=NONE.
  - An aborted burst produces no further `rvalid` and no `dma_done`.
  - Output values: `cpu_gnt`, `dma_gnt`, `cpu_rvalid`, `dma_rvalid`, `dma_done`, `mem_we`=0; `mem_addr`=0.

## Timing
- **Grant:** same-cycle combinational from the request inputs and state. A transfer is accepted on the CLK edge where req&gnt=1.
- **Read latency:** data appears on `rvalid` exactly 1 cycle after acceptance.
- **Burst of N words:**
  - Beats issued on cycles t..t+N-1.
  - `dma_rvalid` asserted on t+1..t+N.
  - `dma_done` asserted on t+N.
- **Back-to-back:** a new request may win in ARB on the cycle after BURST ends, i.e. the same cycle as the last `rvalid`.
- **Worst-case waits:**
  - CPU waits at most 2^BURST_W cycles.
  - DMA waits at most MAX_WAIT+1 ARB cycles.

## Structure
- **Package `hack_bus_pkg`:**
  - `ADDR_W`=15, `DATA_W`=16.
  - `arb_state_t` {ARB, BURST}.
  - `owner_t` {NONE, CPU, DMA}.
- **Sub-module `ram_arb_burst_gen`:**
  - Holds the `len_left` counter and the wrapping `next_addr` register.
  - Inputs: load, advance, start address, length.
  - Outputs: current address, last flag.
- **Top:** holds the FSM, `wait_cnt`, the response-tag register and the memory-port muxing.

## Test plan
- **Reset:** hold `reset`=0 with random inputs → all gnt/rvalid/`mem_we`=0 and `mem_addr`=0; release → ARB state.
- **CPU write then read:** write 0x1234 @0x0010, then read @0x0010 → `cpu_gnt` both cycles; `cpu_rvalid`=1 with `cpu_rdata`=0x1234 one cycle after the read.
- **DMA burst with wrap:** `dma_addr`=0x7FFE, `dma_len`=3 → reads 0x7FFE, 0x7FFF, 0x0000, 0x0001; 4 `dma_rvalid` pulses; `dma_done` on the 4th.
- **Contention:** `cpu_req` and `dma_req` held high, MAX_WAIT=4 → CPU granted 4 cycles, DMA granted on the 5th.
- **Burst blocks CPU:** `dma_len`=15 with `cpu_req` high → `cpu_gnt`=0 for 16 cycles; CPU granted on the cycle after.
- **Reset mid-burst:** reset asserted after beat 2 of 8 → no further `dma_rvalid`; `dma_done` never pulses; next CPU request granted immediately after release.
